// File: rtl/sar_adc_scan.sv
// sar_adc_scan -- multi-channel successive-approximation ADC controller.
//
// Scans the set bits of a latched channel mask from lowest to highest index.
// Each channel gets 2^AVG_LOG2 conversions. Each conversion is SAMPLE_CYCLES
// cycles of track/hold acquisition followed by WIDTH binary-search cycles
// against an external trial DAC and comparator. The truncated average is
// presented for one cycle on a valid strobe. One-shot or continuous
// scanning is supported.
//
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   start         scan request, honoured only in IDLE with a non-zero ch_mask
//   ch_mask       channels to scan, latched when start is accepted
//   cont          continuous mode, sampled when a scan finishes
//   comp_in       comparator, 1 = analog input >= dac_code
//   sample        track/hold control, 1 = track
//   ch_sel        analog mux select (current channel)
//   dac_code      trial code to the DAC (0 outside CONVERT)
//   busy          high whenever the controller is not IDLE
//   data_out      result, held until the next result
//   data_ch       channel of data_out
//   data_valid    one-cycle result strobe
//   done          one-cycle end-of-scan strobe, coincident with the last data_valid
//
// Handshake: data_valid is a strobe with no back-pressure. data_out and
// data_ch are valid in the data_valid cycle and stay stable until the next
// one. The consumer must take the result in that cycle.
//
// The FSM state is held in state_q, a named register of enum type
// state_t, so that checkers can bind to it directly.
module sar_adc_scan #(
   parameter int WIDTH         = 8,
   parameter int NUM_CH        = 4,
   parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int SAMPLE_CYCLES = 2,
   parameter int AVG_LOG2      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              cont,
   input  logic              comp_in,
   output logic              sample,
   output logic [CH_W-1:0]   ch_sel,
   output logic [WIDTH-1:0]  dac_code,
   output logic              busy,
   output logic [WIDTH-1:0]  data_out,
   output logic [CH_W-1:0]   data_ch,
   output logic              data_valid,
   output logic              done
);

   localparam int AW      = WIDTH + AVG_LOG2;
   localparam int RW      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int CNT_MAX = (WIDTH > SAMPLE_CYCLES) ? WIDTH : SAMPLE_CYCLES;
   // The counter holds SAMPLE_CYCLES-1 and WIDTH-1. CNT_MAX is at least 2.
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [RW-1:0]    REP_LAST    = RW'((1 << AVG_LOG2) - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] BIT_MSB     = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SAMPLE  = 2'd1,
      S_CONVERT = 2'd2,
      S_STORE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   // SAMPLE: counts acquisition cycles up. CONVERT: index of the bit under trial.
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [RW-1:0]      rep_q, rep_d;
   logic [WIDTH-1:0]   data_out_q, data_out_d;
   logic [CH_W-1:0]    data_ch_q, data_ch_d;

   logic [WIDTH-1:0]   trial;
   logic [WIDTH-1:0]   decided;
   logic [AW-1:0]      acc_sum;
   logic               hi_found;
   logic [CH_W-1:0]    hi_ch;

   function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
      logic [CH_W-1:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) r = CH_W'(i);
      end
      return r;
   endfunction

   // The partial result has zeros below the bit under trial, so OR-ing in
   // the trial bit gives the code to present. A 0 from the comparator
   // drops the trial bit by keeping the old partial result.
   always_comb begin
      trial   = result_q | (WIDTH'(1) << cnt_q);
      decided = comp_in ? trial : result_q;
      acc_sum = acc_q + AW'(decided);
   end

   // Find the lowest masked channel above the current one. The loop runs
   // downward, so the last hit is the lowest index.
   always_comb begin
      hi_found = 1'b0;
      hi_ch    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_q[i] && (CH_W'(i) > ch_q)) begin
            hi_found = 1'b1;
            hi_ch    = CH_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      ch_d       = ch_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      acc_d      = acc_q;
      rep_d      = rep_q;
      data_out_d = data_out_q;
      data_ch_d  = data_ch_q;

      case (state_q)
         S_IDLE: begin
            if (start && (ch_mask != '0)) begin
               mask_d  = ch_mask;
               ch_d    = lowest_ch(ch_mask);
               cnt_d   = '0;
               acc_d   = '0;
               rep_d   = '0;
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (cnt_q == SAMPLE_LAST) begin
               cnt_d    = BIT_MSB;
               result_d = '0;
               state_d  = S_CONVERT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CONVERT: begin
            result_d = decided;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rep_q == REP_LAST) begin
               // The result register is loaded here so that it is already
               // stable during the STORE strobe.
               data_out_d = WIDTH'(acc_sum >> AVG_LOG2);
               data_ch_d  = ch_q;
               state_d    = S_STORE;
            end else begin
               acc_d   = acc_sum;
               rep_d   = rep_q + RW'(1);
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end
         end
         S_STORE: begin
            cnt_d = '0;
            acc_d = '0;
            rep_d = '0;
            if (hi_found) begin
               ch_d    = hi_ch;
               state_d = S_SAMPLE;
            end else if (cont) begin
               ch_d    = lowest_ch(mask_q);
               state_d = S_SAMPLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mask_q     <= '0;
         ch_q       <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         acc_q      <= '0;
         rep_q      <= '0;
         data_out_q <= '0;
         data_ch_q  <= '0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         ch_q       <= ch_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         acc_q      <= acc_d;
         rep_q      <= rep_d;
         data_out_q <= data_out_d;
         data_ch_q  <= data_ch_d;
      end
   end

   assign sample     = (state_q == S_SAMPLE);
   assign ch_sel     = ch_q;
   assign dac_code   = (state_q == S_CONVERT) ? trial : '0;
   assign busy       = (state_q != S_IDLE);
   assign data_out   = data_out_q;
   assign data_ch    = data_ch_q;
   assign data_valid = (state_q == S_STORE);
   assign done       = (state_q == S_STORE) && !hi_found;

endmodule

// File: tb/tb_sar_adc_scan.sv
// Directed testbench for sar_adc_scan. There are two instances: the default
// configuration and an AVG_LOG2=2 configuration. Each comparator is modelled
// as (vin[ch_sel] >= dac_code).
module tb_sar_adc_scan;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- default instance ----------------
   logic       start   = 1'b0;
   logic [3:0] ch_mask = 4'h0;
   logic       cont    = 1'b0;
   logic       comp_in;
   logic       sample;
   logic [1:0] ch_sel;
   logic [7:0] dac_code;
   logic       busy;
   logic [7:0] data_out;
   logic [1:0] data_ch;
   logic       data_valid;
   logic       done;
   logic [7:0] vin [4];

   assign comp_in = (vin[ch_sel] >= dac_code);

   sar_adc_scan u_dut (
      .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .cont(cont),
      .comp_in(comp_in), .sample(sample), .ch_sel(ch_sel), .dac_code(dac_code),
      .busy(busy), .data_out(data_out), .data_ch(data_ch),
      .data_valid(data_valid), .done(done)
   );

   // ---------------- averaging instance ----------------
   logic       start_a = 1'b0;
   logic [3:0] mask_a  = 4'h0;
   logic       cont_a  = 1'b0;
   logic       comp_a;
   logic       sample_a;
   logic [1:0] ch_sel_a;
   logic [7:0] dac_a;
   logic       busy_a;
   logic [7:0] dout_a;
   logic [1:0] dch_a;
   logic       dv_a;
   logic       done_a;
   logic [7:0] vin_a = 8'h40;
   logic       sample_a_prev = 1'b0;
   int         conv_n = 0;

   assign comp_a = (vin_a >= dac_a);

   sar_adc_scan #(.AVG_LOG2(2)) u_avg (
      .clk(clk), .rst(rst), .start(start_a), .ch_mask(mask_a), .cont(cont_a),
      .comp_in(comp_a), .sample(sample_a), .ch_sel(ch_sel_a), .dac_code(dac_a),
      .busy(busy_a), .data_out(dout_a), .data_ch(dch_a),
      .data_valid(dv_a), .done(done_a)
   );

   // The analog input alternates 0x40 / 0x41, changing at the start of
   // each acquisition window.
   always @(negedge clk) begin
      if (sample_a && !sample_a_prev) begin
         vin_a = conv_n[0] ? 8'h41 : 8'h40;
         conv_n++;
      end
      sample_a_prev = sample_a;
   end

   // ---------------- scoreboard / checks ----------------
   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Cycle 1 is the cycle that follows the start-accept edge.
   task automatic scan_start(input logic [3:0] m);
      start   = 1'b1;
      ch_mask = m;
      @(negedge clk);
      start   = 1'b0;
      cyc     = 1;
   endtask

   task automatic wait_dv(input string tag, input int exp_cyc);
      int guard;
      guard = 0;
      while (!data_valid && guard < 200) begin
         step();
         guard++;
      end
      check({tag, "_dv"}, 32'(data_valid), 32'd1);
      check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic check_result(input string tag, input logic [1:0] ch, input logic dn);
      logic [7:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check({tag, "_data"}, 32'(data_out), 32'(e));
      check({tag, "_ch"}, 32'(data_ch), 32'(ch));
      check({tag, "_done"}, 32'(done), 32'(dn));
   endtask

   logic [7:0] dac_tab [8];
   int n_dv;
   int guard_a;

   initial begin
      dac_tab = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      for (int i = 0; i < 4; i++) vin[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sample", 32'(sample), 32'd0);
      check("rst_dac", 32'(dac_code), 32'd0);
      check("rst_dv", 32'(data_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dout", 32'(data_out), 32'd0);
      check("rst_avg_busy", 32'(busy_a), 32'd0);

      // 1: extremes on channel 0
      vin[0] = 8'h00;
      exp_q.push_back(8'h00);
      scan_start(4'b0001);
      check("t1_busy", 32'(busy), 32'd1);
      wait_dv("t1a", 11);
      check_result("t1a", 2'd0, 1'b1);
      step();
      check("t1a_idle", 32'(busy), 32'd0);
      vin[0] = 8'hFF;
      exp_q.push_back(8'hFF);
      scan_start(4'b0001);
      wait_dv("t1b", 11);
      check_result("t1b", 2'd0, 1'b1);
      step();
      check("t1b_idle", 32'(busy), 32'd0);

      // 2: binary-search trace for 0xA5
      vin[0] = 8'hA5;
      exp_q.push_back(8'hA5);
      scan_start(4'b0001);
      check("t2_s1", 32'({sample, dac_code}), 32'({1'b1, 8'h00}));
      step();
      check("t2_s2", 32'({sample, dac_code}), 32'({1'b1, 8'h00}));
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("t2_dac%0d", k), 32'({sample, dac_code}), 32'({1'b0, dac_tab[k]}));
      end
      wait_dv("t2", 11);
      check_result("t2", 2'd0, 1'b1);
      step();

      // 3: two-channel scan, mask 1010
      vin[1] = 8'h3C;
      vin[3] = 8'hF0;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hF0);
      scan_start(4'b1010);
      check("t3_chsel", 32'(ch_sel), 32'd1);
      wait_dv("t3a", 11);
      check_result("t3a", 2'd1, 1'b0);
      step();
      check("t3_chsel3", 32'(ch_sel), 32'd3);
      wait_dv("t3b", 22);
      check_result("t3b", 2'd3, 1'b1);
      step();
      check("t3_idle", 32'(busy), 32'd0);

      // 4a: start with empty mask is ignored
      start = 1'b1;
      ch_mask = 4'b0000;
      step();
      start = 1'b0;
      check("t4_mask0_busy", 32'(busy), 32'd0);
      step();
      check("t4_mask0_busy2", 32'(busy), 32'd0);

      // 4b: start while busy is ignored
      vin[0] = 8'h55;
      scan_start(4'b0001);
      while (cyc < 5) step();
      start = 1'b1;
      ch_mask = 4'b1111;
      step();
      start = 1'b0;
      ch_mask = 4'b0000;
      check("t4_busy_chsel", 32'(ch_sel), 32'd0);
      n_dv = 0;
      while (cyc < 30) begin
         if (data_valid) begin
            n_dv++;
            check("t4_busy_data", 32'(data_out), 32'h55);
         end
         step();
      end
      check("t4_busy_ndv", 32'(n_dv), 32'd1);
      check("t4_busy_idle", 32'(busy), 32'd0);

      // 4c: reset mid-CONVERT
      scan_start(4'b0001);
      while (cyc < 6) step();
      check("t4_conv_dac", 32'(dac_code != 8'h00), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t4_rst_busy", 32'(busy), 32'd0);
      check("t4_rst_sample", 32'(sample), 32'd0);
      check("t4_rst_dac", 32'(dac_code), 32'd0);
      check("t4_rst_dv_done", 32'({data_valid, done}), 32'd0);
      check("t4_rst_dout", 32'(data_out), 32'd0);
      check("t4_rst_ch", 32'({data_ch, ch_sel}), 32'd0);
      vin[2] = 8'h99;
      exp_q.push_back(8'h99);
      scan_start(4'b0100);
      wait_dv("t4_after", 11);
      check_result("t4_after", 2'd2, 1'b1);
      step();

      // 5: continuous mode, then clear it mid-scan
      vin[0] = 8'h55;
      cont = 1'b1;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h55);
      scan_start(4'b0001);
      wait_dv("t5a", 11);
      check_result("t5a", 2'd0, 1'b1);
      step();
      check("t5_stay_busy", 32'({busy, sample}), 32'b11);
      wait_dv("t5b", 22);
      check_result("t5b", 2'd0, 1'b1);
      step();
      cont = 1'b0;
      check("t5_still_busy", 32'(busy), 32'd1);
      wait_dv("t5c", 33);
      check_result("t5c", 2'd0, 1'b1);
      step();
      check("t5_idle", 32'(busy), 32'd0);

      // 6: averaging instance, 4 conversions of 0x40/0x41 -> 0x40
      start_a = 1'b1;
      mask_a  = 4'b0001;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 1;
      guard_a = 0;
      while (!dv_a && guard_a < 200) begin
         step();
         guard_a++;
      end
      check("t6_dv", 32'(dv_a), 32'd1);
      check("t6_cyc", 32'(cyc), 32'd41);
      check("t6_data", 32'(dout_a), 32'h40);
      check("t6_ch_done", 32'({dch_a, done_a}), 32'({2'd0, 1'b1}));
      check("t6_nconv", 32'(conv_n), 32'd4);
      step();
      check("t6_idle", 32'(busy_a), 32'd0);
      check("t6_main_quiet", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
